// File: rtl/seq_alu.sv
// Registered ARM data-processing ALU with an iterative shift-add MUL/MLA path.
// Issue and result sides use valid/ready; one operation is in flight at a time.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             in_Clk,
    input  logic             in_Rst,
    input  logic             in_Valid,
    output logic             out_Ready,
    input  logic [WIDTH-1:0] in_Rn,
    input  logic [WIDTH-1:0] in_Op2,
    input  logic [WIDTH-1:0] in_Acc,
    input  logic             in_Barrel_carry,
    input  logic [3:0]       in_Opcode,
    input  logic             in_Mul,
    input  logic             in_Accumulate,
    input  logic [3:0]       in_CNZV,
    input  logic             in_Set_cond,
    output logic             out_Valid,
    input  logic             in_ResultReady,
    output logic [WIDTH-1:0] out_Y,
    output logic             out_WriteEn,
    output logic [3:0]       out_CNZV
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [3:0]       cnzv_q, cnzv_d;
    logic             we_q, we_d;
    logic             mset_q, mset_d;
    logic [3:0]       mflags_q, mflags_d;

    logic signed [WIDTH-1:0] add_a, add_b;
    logic                    add_cin;
    logic                    arith;
    logic [WIDTH-1:0]        logic_y;
    logic [WIDTH:0]          add_sum;
    logic [WIDTH-1:0]        alu_y;
    logic [3:0]              alu_cnzv;
    logic                    alu_we;
    logic [WIDTH-1:0]        mul_sum;

    function automatic logic signed_ovf(input logic signed [WIDTH-1:0] a,
                                        input logic signed [WIDTH-1:0] b,
                                        input logic signed [WIDTH-1:0] r);
        return ((a < 0) == (b < 0)) && ((r < 0) != (a < 0));
    endfunction

    // Subtractions reuse the adder: invert the subtrahend and feed 1 (or C) as carry-in.
    always_comb begin
        add_a   = in_Rn;
        add_b   = in_Op2;
        add_cin = 1'b0;
        arith   = 1'b1;
        case (in_Opcode)
            4'h2, 4'hA: begin add_b = ~in_Op2; add_cin = 1'b1; end
            4'h3:       begin add_a = in_Op2; add_b = ~in_Rn; add_cin = 1'b1; end
            4'h4, 4'hB: begin add_cin = 1'b0; end
            4'h5:       begin add_cin = in_CNZV[3]; end
            4'h6:       begin add_b = ~in_Op2; add_cin = in_CNZV[3]; end
            4'h7:       begin add_a = in_Op2; add_b = ~in_Rn; add_cin = in_CNZV[3]; end
            default:    begin arith = 1'b0; end
        endcase
    end

    always_comb begin
        logic_y = '0;
        case (in_Opcode)
            4'h0, 4'h8: logic_y = in_Rn & in_Op2;
            4'h1, 4'h9: logic_y = in_Rn ^ in_Op2;
            4'hC:       logic_y = in_Rn | in_Op2;
            4'hD:       logic_y = in_Op2;
            4'hE:       logic_y = in_Rn & ~in_Op2;
            4'hF:       logic_y = ~in_Op2;
            default:    logic_y = '0;
        endcase
    end

    assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    assign alu_y   = arith ? add_sum[WIDTH-1:0] : logic_y;
    assign alu_we  = (in_Opcode[3:2] != 2'b10);

    always_comb begin
        alu_cnzv = in_CNZV;
        if (in_Set_cond) begin
            if (arith)
                alu_cnzv = {add_sum[WIDTH], alu_y[WIDTH-1], (alu_y == '0),
                            signed_ovf(add_a, add_b, alu_y)};
            else
                alu_cnzv = {in_Barrel_carry, alu_y[WIDTH-1], (alu_y == '0), in_CNZV[0]};
        end
    end

    assign mul_sum = mplier_q[0] ? (sum_q + mcand_q) : sum_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        sum_d    = sum_q;
        y_d      = y_q;
        cnzv_d   = cnzv_q;
        we_d     = we_q;
        mset_d   = mset_q;
        mflags_d = mflags_q;
        case (state_q)
            ST_IDLE: begin
                if (in_Valid) begin
                    if (in_Mul) begin
                        state_d  = ST_MUL;
                        cnt_d    = '0;
                        mcand_d  = in_Rn;
                        mplier_d = in_Op2;
                        // Seeding the partial sum with the addend makes MLA free.
                        sum_d    = in_Accumulate ? in_Acc : '0;
                        mset_d   = in_Set_cond;
                        mflags_d = in_CNZV;
                    end else begin
                        state_d = ST_DONE;
                        y_d     = alu_y;
                        cnzv_d  = alu_cnzv;
                        we_d    = alu_we;
                    end
                end
            end
            ST_MUL: begin
                sum_d    = mul_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                    y_d     = mul_sum;
                    we_d    = 1'b1;
                    cnzv_d  = mset_q ? {mflags_q[3], mul_sum[WIDTH-1], (mul_sum == '0), mflags_q[0]}
                                     : mflags_q;
                end
            end
            ST_DONE: begin
                if (in_ResultReady)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge in_Clk) begin
        if (in_Rst) begin
            state_q <= ST_IDLE;
            y_q     <= '0;
            cnzv_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            cnzv_q  <= cnzv_d;
            we_q    <= we_d;
        end
    end

    // Multiplier working registers are don't-care outside MUL, so they carry no reset.
    always_ff @(posedge in_Clk) begin
        cnt_q    <= cnt_d;
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        sum_q    <= sum_d;
        mset_q   <= mset_d;
        mflags_q <= mflags_d;
    end

    assign out_Ready   = (state_q == ST_IDLE);
    assign out_Valid   = (state_q == ST_DONE);
    assign out_Y       = y_q;
    assign out_CNZV    = cnzv_q;
    assign out_WriteEn = we_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: arithmetic reference model, per-cycle result scoreboard,
// plus directed checks on handshake timing, back-pressure and reset abort.
module tb_seq_alu;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_Valid, out_Ready;
    logic [W-1:0]  in_Rn, in_Op2, in_Acc;
    logic          in_Barrel_carry;
    logic [3:0]    in_Opcode;
    logic          in_Mul, in_Accumulate;
    logic [3:0]    in_CNZV;
    logic          in_Set_cond;
    logic          out_Valid, rr;
    logic [W-1:0]  out_Y;
    logic          out_WriteEn;
    logic [3:0]    out_CNZV;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct packed {
        logic [31:0] y;
        logic [3:0]  f;
        logic        we;
    } res_t;

    typedef struct {
        res_t r;
        int   due;
        bit   seen;
    } exp_t;

    exp_t exp_q[$];

    seq_alu #(.WIDTH(W), .CNT_W(6)) dut (
        .in_Clk(clk), .in_Rst(rst), .in_Valid(in_Valid), .out_Ready(out_Ready),
        .in_Rn(in_Rn), .in_Op2(in_Op2), .in_Acc(in_Acc),
        .in_Barrel_carry(in_Barrel_carry), .in_Opcode(in_Opcode),
        .in_Mul(in_Mul), .in_Accumulate(in_Accumulate), .in_CNZV(in_CNZV),
        .in_Set_cond(in_Set_cond), .out_Valid(out_Valid),
        .in_ResultReady(rr), .out_Y(out_Y), .out_WriteEn(out_WriteEn),
        .out_CNZV(out_CNZV)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on 64-bit values, flags from ranges.
    function automatic res_t model(input logic mul, input logic mla, input logic [3:0] op,
                                   input logic [31:0] rn, input logic [31:0] op2,
                                   input logic [31:0] acc, input logic bc,
                                   input logic [3:0] f, input logic s);
        res_t r;
        longint unsigned ua, ub, u, two32, nbu, ciu;
        longint sa, sb, sv, nbs, cis;
        logic c, v, arith;
        two32 = 64'h1_0000_0000;
        ua = {32'b0, rn};
        ub = {32'b0, op2};
        sa = longint'($signed(rn));
        sb = longint'($signed(op2));
        ciu = f[3] ? 64'd1 : 64'd0;
        nbu = f[3] ? 64'd0 : 64'd1;
        cis = f[3] ? 1 : 0;
        nbs = f[3] ? 0 : 1;
        u = 0; sv = 0; arith = 1'b1;
        r.y = '0;
        r.we = mul || (op[3:2] != 2'b10);
        if (mul) begin
            u = ua * ub + (mla ? {32'b0, acc} : 64'd0);
            r.y = u[31:0];
        end else begin
            case (op)
                4'h4, 4'hB: begin u = ua + ub;               sv = sa + sb; end
                4'h5:       begin u = ua + ub + ciu;         sv = sa + sb + cis; end
                4'h2, 4'hA: begin u = ua + two32 - ub;       sv = sa - sb; end
                4'h3:       begin u = ub + two32 - ua;       sv = sb - sa; end
                4'h6:       begin u = ua + two32 - ub - nbu; sv = sa - sb - nbs; end
                4'h7:       begin u = ub + two32 - ua - nbu; sv = sb - sa - nbs; end
                default:    arith = 1'b0;
            endcase
            if (arith) r.y = u[31:0];
            else case (op)
                4'h0, 4'h8: r.y = rn & op2;
                4'h1, 4'h9: r.y = rn ^ op2;
                4'hC:       r.y = rn | op2;
                4'hD:       r.y = op2;
                4'hE:       r.y = rn & ~op2;
                default:    r.y = ~op2;
            endcase
        end
        c = (u >= two32);
        v = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
        if (!s)         r.f = f;
        else if (mul)   r.f = {f[3], r.y[31], r.y == 0, f[0]};
        else if (arith) r.f = {c, r.y[31], r.y == 0, v};
        else            r.f = {bc, r.y[31], r.y == 0, f[0]};
        return r;
    endfunction

    task automatic issue(input logic mul, input logic mla, input logic [3:0] op,
                         input logic [31:0] rn, input logic [31:0] op2, input logic [31:0] acc,
                         input logic bc, input logic [3:0] f, input logic s, output int waited);
        exp_t e;
        waited = 0;
        @(negedge clk);
        in_Mul = mul; in_Accumulate = mla; in_Opcode = op; in_Rn = rn; in_Op2 = op2;
        in_Acc = acc; in_Barrel_carry = bc; in_CNZV = f; in_Set_cond = s; in_Valid = 1'b1;
        while (!out_Ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("issue_accept", 64'(out_Ready), 64'd1);
        if (!out_Ready) begin
            in_Valid = 1'b0;
            return;
        end
        e.r = model(mul, mla, op, rn, op2, acc, bc, f, s);
        e.due = cyc + (mul ? (W + 1) : 1);
        e.seen = 1'b0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_Valid = 1'b0;
        in_Rn = $urandom; in_Op2 = $urandom; in_Acc = $urandom;
        in_Opcode = 4'($urandom); in_CNZV = 4'($urandom);
        in_Barrel_carry = 1'($urandom); in_Set_cond = 1'($urandom);
        in_Mul = 1'($urandom); in_Accumulate = 1'($urandom);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Scoreboard: every cycle a result is offered it must match the head entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && out_Valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 64'(out_Valid), 64'd0);
                end else begin
                    e = exp_q[0];
                    if (!e.seen) begin
                        check("latency", 64'(cyc), 64'(e.due));
                        e.seen = 1'b1;
                        exp_q[0] = e;
                    end
                    check("out_Y", 64'(out_Y), 64'(e.r.y));
                    check("out_CNZV", 64'(out_CNZV), 64'(e.r.f));
                    check("out_WriteEn", 64'(out_WriteEn), 64'(e.r.we));
                    if (rr) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        res_t m;
        int w, n0, first;
        rst = 1'b1; in_Valid = 1'b0; rr = 1'b1;
        in_Rn = '0; in_Op2 = '0; in_Acc = '0; in_Barrel_carry = 1'b0; in_Opcode = '0;
        in_Mul = 1'b0; in_Accumulate = 1'b0; in_CNZV = '0; in_Set_cond = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #2;
        check("rst_valid", 64'(out_Valid), 64'd0);
        check("rst_y", 64'(out_Y), 64'd0);
        check("rst_cnzv", 64'(out_CNZV), 64'd0);
        check("rst_we", 64'(out_WriteEn), 64'd0);
        check("rst_ready", 64'(out_Ready), 64'd1);

        // Hand-computed anchors for the reference model.
        m = model(0, 0, 4'h4, 32'd2, 32'd3, 0, 0, 4'b0000, 1);
        check("pin_add", 64'(m), 64'({32'd5, 4'b0000, 1'b1}));
        m = model(0, 0, 4'h2, 32'd0, 32'd1, 0, 0, 4'b0000, 1);
        check("pin_sub", 64'(m), 64'({32'hFFFFFFFF, 4'b0100, 1'b1}));
        m = model(0, 0, 4'h4, 32'h7FFFFFFF, 32'd1, 0, 0, 4'b0000, 1);
        check("pin_add_ovf", 64'(m), 64'({32'h80000000, 4'b0101, 1'b1}));
        m = model(0, 0, 4'hA, 32'd5, 32'd5, 0, 0, 4'b0000, 1);
        check("pin_cmp", 64'(m), 64'({32'd0, 4'b1010, 1'b0}));
        m = model(0, 0, 4'hA, 32'd5, 32'd5, 0, 0, 4'b0101, 0);
        check("pin_cmp_nos", 64'(m), 64'({32'd0, 4'b0101, 1'b0}));
        m = model(1, 1, 4'h0, 32'd3, 32'd4, 32'd5, 0, 4'b1001, 1);
        check("pin_mla", 64'(m), 64'({32'd17, 4'b1001, 1'b1}));
        m = model(1, 0, 4'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 4'b0000, 1);
        check("pin_mul_ff", 64'(m), 64'({32'd1, 4'b0000, 1'b1}));
        m = model(0, 0, 4'h6, 32'd5, 32'd3, 0, 0, 4'b0000, 1);
        check("pin_sbc", 64'(m), 64'({32'd1, 4'b1000, 1'b1}));

        // Data-processing vectors.
        issue(0, 0, 4'h4, 32'd2, 32'd3, 0, 0, 4'b0000, 1, w);
        issue(0, 0, 4'h2, 32'd0, 32'd1, 0, 0, 4'b0000, 1, w);
        issue(0, 0, 4'h4, 32'h7FFFFFFF, 32'd1, 0, 0, 4'b0000, 1, w);
        issue(0, 0, 4'hA, 32'd5, 32'd5, 0, 0, 4'b0000, 1, w);
        issue(0, 0, 4'hA, 32'd5, 32'd5, 0, 0, 4'b0101, 0, w);
        issue(0, 0, 4'h5, 32'hFFFFFFFF, 32'd0, 0, 0, 4'b1000, 1, w);
        issue(0, 0, 4'h6, 32'd5, 32'd3, 0, 0, 4'b0000, 1, w);
        issue(0, 0, 4'h7, 32'd3, 32'd5, 0, 0, 4'b1000, 1, w);
        issue(0, 0, 4'h3, 32'd1, 32'd0, 0, 0, 4'b0000, 1, w);
        issue(0, 0, 4'hB, 32'h80000000, 32'h80000000, 0, 0, 4'b0000, 1, w);
        issue(0, 0, 4'h0, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 1, 4'b0001, 1, w);
        issue(0, 0, 4'h1, 32'hAAAA5555, 32'hAAAA5555, 0, 1, 4'b0001, 1, w);
        issue(0, 0, 4'h8, 32'h00000001, 32'h00000003, 0, 0, 4'b1111, 1, w);
        issue(0, 0, 4'h9, 32'h80000000, 32'h00000000, 0, 1, 4'b0000, 1, w);
        issue(0, 0, 4'hE, 32'hFFFFFFFF, 32'h0000FFFF, 0, 0, 4'b1001, 1, w);
        issue(0, 0, 4'hF, 32'd0, 32'd0, 0, 1, 4'b0000, 1, w);
        issue(0, 0, 4'hD, 32'd0, 32'd0, 0, 1, 4'b0000, 1, w);
        wait_drain();

        // MLA timing: ready stays low through MUL and the DONE cycle.
        issue(1, 1, 4'h0, 32'd3, 32'd4, 32'd5, 0, 4'b1001, 1, w);
        n0 = 0; first = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            #2;
            if (!out_Ready) n0++;
            if (out_Valid && first == 0) first = i;
        end
        check("mla_ready_low", 64'(n0), 64'd33);
        check("mla_valid_cycle", 64'(first), 64'd33);
        issue(1, 0, 4'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 4'b0000, 1, w);
        issue(1, 0, 4'h0, 32'd0, 32'h12345678, 0, 0, 4'b1111, 1, w);
        issue(1, 1, 4'h0, 32'h0001_0000, 32'h0001_0000, 32'd7, 1, 4'b0110, 0, w);
        wait_drain();

        // Back-pressure: result held for three cycles, then released.
        rr = 1'b0;
        issue(0, 0, 4'hC, 32'hF0, 32'h0F, 0, 0, 4'b0000, 1, w);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #2;
            check("bp_valid", 64'(out_Valid), 64'd1);
            check("bp_ready", 64'(out_Ready), 64'd0);
            check("bp_y", 64'(out_Y), 64'hFF);
        end
        @(negedge clk);
        rr = 1'b1;
        #2;
        check("bp_y_last", 64'(out_Y), 64'hFF);
        @(negedge clk);
        #2;
        check("bp_release_ready", 64'(out_Ready), 64'd1);
        check("bp_release_valid", 64'(out_Valid), 64'd0);
        issue(0, 0, 4'h2, 32'd0, 32'd1, 0, 0, 4'b0000, 1, w);
        check("bp_next_issue_wait", 64'(w), 64'd0);
        wait_drain();

        // Reset partway through a multiply discards it.
        issue(1, 0, 4'h0, 32'h1234, 32'h5678, 0, 0, 4'b0000, 1, w);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("abort_valid", 64'(out_Valid), 64'd0);
        check("abort_y", 64'(out_Y), 64'd0);
        check("abort_cnzv", 64'(out_CNZV), 64'd0);
        check("abort_ready", 64'(out_Ready), 64'd1);
        issue(0, 0, 4'h4, 32'd1, 32'd1, 0, 0, 4'b0000, 0, w);
        @(negedge clk);
        #2;
        check("after_abort_y", 64'(out_Y), 64'd2);
        wait_drain();

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the combinational data-processing ALU.
- Executes all 16 ARM data-processing opcodes in one cycle, plus an iterative MUL/MLA path (radix-2 shift-add, one bit per cycle).
- Uses a valid/ready handshake on both the issue and result sides, so the execute stage can stall on multiplies and on back-pressure from writeback.

Parameters:
- WIDTH, 32: operand/result width in bits (>=8).
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- in_Clk  input  1  clock; all state updates on rising edge.
- in_Rst  input  1  synchronous, active-high reset.
- in_Valid  input  1  issue request.
- out_Ready  output  1  block can accept an issue; high only in IDLE.
- in_Rn  input  WIDTH  first operand; multiplicand for MUL/MLA.
- in_Op2  input  WIDTH  shifted second operand; multiplier for MUL/MLA.
- in_Acc  input  WIDTH  accumulate addend, used by MLA only.
- in_Barrel_carry  input  1  shifter carry-out.
- in_Opcode  input  4  ARM DP opcode: AND 0, EOR 1, SUB 2, RSB 3, ADD 4, ADC 5, SBC 6, RSC 7, TST 8, TEQ 9, CMP A, CMN B, ORR C, MOV D, BIC E, MVN F.
- in_Mul  input  1  1 = multiply class; in_Opcode is ignored.
- in_Accumulate  input  1  with in_Mul: 1 = MLA, 0 = MUL.
- in_CNZV  input  4  current flags {C,N,Z,V}.
- in_Set_cond  input  1  update flags.
- out_Valid  output  1  result available.
- in_ResultReady  input  1  consumer accepts result.
- out_Y  output  WIDTH  result.
- out_WriteEn  output  1  result targets a register (0 for TST/TEQ/CMP/CMN).
- out_CNZV  output  4  new flags.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - Outputs: out_Valid=0, out_Y=0, out_CNZV=0, out_WriteEn=0, out_Ready=1 (from the cycle after reset deasserts).
  - Reset during MUL or DONE aborts the operation and discards the result.
- Issue:
  - Accepted on an edge where in_Valid && out_Ready.
  - All operands and controls are captured at that edge; later input changes have no effect.
- State machine:
  - IDLE -> DONE on accept of a DP op.
  - IDLE -> MUL on accept of a multiply op; counter cleared.
  - MUL -> DONE after WIDTH iterations.
  - DONE -> IDLE on an edge with in_ResultReady=1.
- Latency: out_Valid rises 1 cycle after accept for DP ops, and WIDTH+1 cycles after accept for MUL/MLA.
- Back-pressure:
  - In DONE, out_Y, out_CNZV and out_WriteEn are held stable while in_ResultReady=0.
  - out_Ready=0 in MUL and DONE. An issue and a result handoff never overlap in the same cycle.
- Arithmetic: all arithmetic is modulo 2^WIDTH.
  - ADD/CMN: Rn+Op2.
  - ADC: Rn+Op2+C.
  - SUB/CMP: Rn-Op2.
  - RSB: Op2-Rn.
  - SBC: Rn-Op2-!C.
  - RSC: Op2-Rn-!C.
  - Subtraction is implemented as add-with-inverted-operand.
- Flags: out_CNZV = in_CNZV whenever in_Set_cond=0. When in_Set_cond=1:
  - N = MSB of result.
  - Z = (result==0).
  - Arithmetic ops: C = carry out of the WIDTH-bit adder (subtract C = NOT borrow); V = signed overflow.
  - Logical ops (AND EOR TST TEQ ORR MOV BIC MVN): C = in_Barrel_carry, V unchanged.
  - MUL/MLA: N and Z updated; C and V unchanged.
- Multiply:
  - Product is Rn*Op2, low WIDTH bits only; MLA adds in_Acc modulo 2^WIDTH.
  - Each cycle: add the shifted multiplicand into the partial sum if the current multiplier bit is 1, then shift.
  - Zero operands still take the full WIDTH cycles (fixed latency).
- out_WriteEn: 0 for opcodes 8-B when in_Mul=0; 1 otherwise. For TST/TEQ/CMP/CMN, out_Y still carries the computed value.

Test Plan (WIDTH=32, in_ResultReady=1 unless stated):
- ADD 2,3, Set_cond=1, CNZV=0000 -> one cycle later out_Valid=1, out_Y=5, CNZV=0000, out_WriteEn=1.
- SUB 0,1 -> out_Y=FFFFFFFF, C=0, N=1, Z=0, V=0. ADD 7FFFFFFF,1 -> out_Y=80000000, N=1, V=1, C=0.
- CMP 5,5 with Set_cond=1 -> Z=1, C=1, out_WriteEn=0. Repeat with Set_cond=0 and CNZV=0101 -> out_CNZV=0101.
- MLA Rn=3, Op2=4, Acc=5, CNZV=1001, Set_cond=1 -> out_Ready=0 for 33 cycles; out_Valid on cycle 33 after accept; out_Y=17, CNZV=1001. Also FFFFFFFF*FFFFFFFF -> out_Y=00000001.
- Back-pressure: hold in_ResultReady=0 for 3 cycles after ORR F0,0F -> out_Y=FF stable, out_Valid=1, out_Ready=0. Release -> IDLE next edge; a new issue is accepted the following cycle.
- Assert in_Rst at iteration 10 of a MUL -> next cycle out_Valid=0, out_Y=0, out_CNZV=0, out_Ready=1. A following ADD 1,1 returns 2.
